load_store_unit: RTL and testbench

Load/store sequencer between the execute stage and the 1024×32 word-addressed data RAM. It accepts one byte, halfword or word access per handshake and drives the RAM's write_enable/address/data_in. Loads are returned sign- or zero-extended. Sub-word stores are performed as read-modify-write, because the RAM has no byte enables.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam int WORD_IDX_W = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF)  mis = offset[0];
    else if (size[1])     mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension,
// and merge of sub-word store data into the word read back from RAM.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no case arm can infer a latch.
    byte_v       = 8'h00;
    half_v       = 16'h0000;
    load_data_o  = rdata_i;
    store_data_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        byte_v       = rdata_i[{offset_i, 3'b000} +: 8];
        load_data_o  = {{24{~unsigned_i & byte_v[7]}}, byte_v};
        store_data_o = rdata_i;
        store_data_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        // offset[0] is ignored, which also aligns misaligned halves down.
        half_v       = rdata_i[{offset_i[1], 4'b0000} +: 16];
        load_data_o  = {{16{~unsigned_i & half_v[15]}}, half_v};
        store_data_o = rdata_i;
        store_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o  = rdata_i;
        store_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer to a 1024x32 word RAM; sub-word stores use read-modify-write.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [WORD_IDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_e            state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            offset_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  mem_we_q;
  logic [WORD_IDX_W-1:0] mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  resp_valid_q;
  logic [DATA_W-1:0]     resp_rdata_q;
  logic                  resp_err_q;

  logic                  trap_hs;
  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     store_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hs = is_misaligned(req_size, req_addr[1:0]);
`else
  assign trap_hs = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .size_i       (size_q),
    .offset_i     (offset_q),
    .unsigned_i   (unsigned_q),
    .rdata_i      (mem_rdata),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      offset_q     <= 2'b00;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            offset_q   <= req_addr[1:0];
            wdata_q    <= req_wdata;
            if (trap_hs) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              mem_addr_q <= req_addr[ADDR_W-1:2];
              if (req_we && req_size[1]) begin
                mem_wdata_q <= req_wdata;
                mem_we_q    <= 1'b1;
                state_q     <= ST_WR;
              end else begin
                state_q <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          // Read data is consumed here: merged for stores, extracted for loads.
          if (we_q) begin
            mem_wdata_q <= store_data;
            mem_we_q    <= 1'b1;
            state_q     <= ST_WR;
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data follows the address within the cycle, writes land on the edge.
  logic [31:0] ram [0:1023];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  // Reference: plain byte-addressed little-endian memory.
  logic [7:0] mem_b [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          we_cnt   = 0;
  logic [9:0]  exp_we_idx  = '0;
  logic [31:0] exp_we_data = '0;
  logic [9:0]  prev_idx    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [11:0] a);
    int b;
    b = int'(a) & ~3;
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  // Response monitor: pops the scoreboard whenever the DUT completes.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {31'd0, resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_latency", cyc, e.due);
      end
    end
  end

  // RAM write monitor: every write pulse must carry the model's full word.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      check("we_addr", {22'd0, mem_addr}, {22'd0, exp_we_idx});
      check("we_data", mem_wdata, exp_we_data);
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          lat;
    int          we_exp;
    int          nb;
    int          a;
    int          we0;
    int          k;
    logic [31:0] v;
    logic [9:0]  idx_exp;
    logic        mis;

    mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a   = int'(addr) & ~(nb - 1);
    e.rdata = '0;
    e.err   = 1'b0;
    we_exp  = 0;
    lat     = 1;
    idx_exp = 10'(a >> 2);
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.err   = 1'b1;
      lat     = 0;
      idx_exp = prev_idx;
    end else
`endif
    if (!we) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a+i]) << (8 * i));
      if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
    end else begin
      for (int i = 0; i < nb; i++) mem_b[a+i] = wdata[8*i +: 8];
      lat         = (nb == 4) ? 1 : 2;
      we_exp      = 1;
      exp_we_idx  = 10'(a >> 2);
      exp_we_data = word_at(12'(a));
    end
    if (mis) begin end

    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    we0          = we_cnt;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    e.due = cyc + lat;
    sb.push_back(e);
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 12'($urandom);
    req_wdata    = $urandom;

    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (req_ready) break;
      k++;
    end
    check("done_in_time", {31'd0, (k < 20)}, 32'd1);
    check("resp_seen", sb.size(), 32'd0);
    sb.delete();
    check("we_pulses", we_cnt - we0, we_exp);
    check("mem_addr_hold", {22'd0, mem_addr}, {22'd0, idx_exp});
    prev_idx = idx_exp;
  endtask

  // Reset lands in the RD cycle of a byte store; nothing may be written or answered.
  task automatic reset_mid_store(input logic [11:0] addr);
    int we0;
    @(negedge clk);
    we0          = we_cnt;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = addr;
    req_wdata    = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_we_pulses", we_cnt - we0, 32'd0);
    prev_idx = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // NOTE: the RAM and model are cleared here only; real RAM contents are not reset.
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 4096; i++) mem_b[i] = '0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    #2;
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", {31'd0, resp_err}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 12'h012, 32'h0000_0055);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    check("plan_rmw_word", word_at(12'h010), 32'hDE55_BEEF);

    issue(1'b1, 2'b10, 1'b0, 12'h020, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) issue(1'b0, 2'b00, 1'b0, 12'(32'h020 + i), 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'h022, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 12'h022, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 12'h020, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h1234_5678);
    issue(1'b0, 2'b00, 1'b0, 12'hFFF, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 12'hFFE, 32'h0000_CAFE);
    issue(1'b0, 2'b01, 1'b1, 12'hFFE, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 12'h000, 32'h0000_A5C3);
    issue(1'b0, 2'b01, 1'b0, 12'h001, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 12'h023, 32'h0000_1111);
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);

    reset_mid_store(12'h021);
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);

    for (int n = 0; n < 250; n++) begin
      logic [11:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 31)) : 12'($urandom);
      issue(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
